// File: rtl/dom_and_sched.sv
// rtl/dom_and_sched.sv - round-robin scheduler sharing one DOM AND gadget among masked requesters
module dom_and_sched #(
    parameter int N_REQ  = 4,
    parameter int ID_W   = 2,
    parameter int LFSR_W = 32
) (
    input  logic              clock_0,
    input  logic              reset_0,
    input  logic              seed_valid,
    input  logic [LFSR_W-1:0] seed,
    input  logic [N_REQ-1:0]  req_valid,
    input  logic [N_REQ-1:0]  req_a_s0,
    input  logic [N_REQ-1:0]  req_a_s1,
    input  logic [N_REQ-1:0]  req_b_s0,
    input  logic [N_REQ-1:0]  req_b_s1,
    output logic [N_REQ-1:0]  req_ready,
    output logic              g_i0_s0,
    output logic              g_i0_s1,
    output logic              g_i1_s0,
    output logic              g_i1_s1,
    output logic              g_rand,
    input  logic              g_o0_s0,
    input  logic              g_o0_s1,
    output logic [N_REQ-1:0]  rsp_valid,
    output logic              rsp_s0,
    output logic              rsp_s1,
    output logic [ID_W-1:0]   rsp_id,
    output logic              seeded
);

    typedef enum logic {SEED_WAIT, RUN} state_t;

    // Tap positions of x^32+x^22+x^2+x+1 in a right-shifting Fibonacci register
    localparam int TAP_22 = LFSR_W - 22;
    localparam int TAP_2  = LFSR_W - 2;
    localparam int TAP_1  = LFSR_W - 1;

    state_t            state, state_nxt;
    logic [LFSR_W-1:0] lfsr, lfsr_nxt;
    logic [ID_W-1:0]   ptr, ptr_nxt;
    logic              t1_valid, t2_valid;
    logic [ID_W-1:0]   t1_id, t2_id;
    logic              grant_any;
    logic [ID_W-1:0]   grant_id;
    logic [N_REQ-1:0]  grant;
    logic              feedback;
    logic              seed_ok;

    assign seed_ok  = seed_valid && (|seed);
    assign feedback = lfsr[0] ^ lfsr[TAP_22] ^ lfsr[TAP_2] ^ lfsr[TAP_1];

    // Walk downward so the requester closest to the pointer is the last (winning) assignment
    always_comb begin
        logic [ID_W:0] sum;
        grant_any = 1'b0;
        grant_id  = '0;
        sum       = '0;
        if (state == RUN) begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
                sum = {1'b0, ptr} + (ID_W + 1)'(k);
                if (sum >= (ID_W + 1)'(N_REQ)) begin
                    sum = sum - (ID_W + 1)'(N_REQ);
                end
                if (req_valid[sum[ID_W-1:0]]) begin
                    grant_any = 1'b1;
                    grant_id  = sum[ID_W-1:0];
                end
            end
        end
    end

    assign grant     = grant_any ? (N_REQ'(1) << grant_id) : '0;
    assign req_ready = grant;

    // Per-share AND-OR selection keeps s0 and s1 in disjoint logic cones
    assign g_i0_s0 = |(grant & req_a_s0);
    assign g_i0_s1 = |(grant & req_a_s1);
    assign g_i1_s0 = |(grant & req_b_s0);
    assign g_i1_s1 = |(grant & req_b_s1);
    assign g_rand  = (state == RUN) ? lfsr[0] : 1'b0;
    assign seeded  = (state == RUN);

    always_comb begin
        state_nxt = state;
        lfsr_nxt  = lfsr;
        ptr_nxt   = ptr;
        case (state)
            SEED_WAIT: begin
                if (seed_ok) begin
                    lfsr_nxt  = seed;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (seed_ok) begin
                    lfsr_nxt = seed;
                end else begin
                    lfsr_nxt = {feedback, lfsr[LFSR_W-1:1]};
                end
                if (grant_any) begin
                    ptr_nxt = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
                end
            end
            default: state_nxt = SEED_WAIT;
        endcase
    end

    always_ff @(posedge clock_0 or negedge reset_0) begin
        if (!reset_0) begin
            state    <= SEED_WAIT;
            lfsr     <= '0;
            ptr      <= '0;
            t1_valid <= 1'b0;
            t1_id    <= '0;
            t2_valid <= 1'b0;
            t2_id    <= '0;
        end else begin
            state    <= state_nxt;
            lfsr     <= lfsr_nxt;
            ptr      <= ptr_nxt;
            t1_valid <= grant_any;
            t1_id    <= grant_id;
            t2_valid <= t1_valid;
            t2_id    <= t1_id;
        end
    end

    assign rsp_valid = t2_valid ? (N_REQ'(1) << t2_id) : '0;
    assign rsp_id    = t2_valid ? t2_id : '0;
    assign rsp_s0    = t2_valid & g_o0_s0;
    assign rsp_s1    = t2_valid & g_o0_s1;

endmodule

// File: doc/dom_and_sched.md
Name: dom_and_sched

Overview:
- Scheduler that shares one first-order DOM AND gadget (2 shares, 1 fresh random bit per operation, 2-cycle latency) among N_REQ masked requesters.
- Arbitrates requests round-robin and drives the gadget's share inputs and fresh-randomness bit from an internal LFSR.
- Tracks in-flight operations and routes each masked result back to its requester.
- Sits between masked-logic clients (e.g. S-box share pipelines) and a single externally instantiated DOM AND gadget.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester index width; equals clog2(N_REQ).
- LFSR_W, 32, fresh-randomness LFSR width; feedback polynomial fixed at x^32+x^22+x^2+x+1, Fibonacci form, shift toward bit 0.

Ports:
- clock_0  in  1  single clock, rising edge.
- reset_0  in  1  asynchronous, active-low reset.
- seed_valid  in  1  load seed this cycle.
- seed  in  LFSR_W  LFSR seed; all-zero is ignored.
- req_valid  in  N_REQ  per-requester operation request.
- req_a_s0, req_a_s1  in  N_REQ  per-requester operand A shares.
- req_b_s0, req_b_s1  in  N_REQ  per-requester operand B shares.
- req_ready  out  N_REQ  one-hot grant (combinational).
- g_i0_s0, g_i0_s1, g_i1_s0, g_i1_s1  out  1  gadget operand shares.
- g_rand  out  1  gadget fresh random bit.
- g_o0_s0, g_o0_s1  in  1  gadget output shares.
- rsp_valid  out  N_REQ  one-hot result strobe, 1 cycle.
- rsp_s0, rsp_s1  out  1  result shares.
- rsp_id  out  ID_W  index of the result owner.
- seeded  out  1  high in RUN.

Behaviour:
- Reset (reset_0=0) clears the following:
  - all outputs to 0;
  - LFSR to 0;
  - round-robin pointer to 0;
  - both tag-pipeline stages to invalid;
  - state to SEED_WAIT.
- Reset mid-operation discards in-flight results; no rsp_valid is produced for them.
- FSM SEED_WAIT:
  - req_ready=0; gadget inputs and g_rand held at 0; LFSR frozen.
  - seed_valid=1 with nonzero seed: LFSR<=seed, next state RUN.
  - seed_valid=1 with zero seed: ignored.
- FSM RUN:
  - LFSR advances one step every cycle, including idle cycles.
  - seed_valid=1 with nonzero seed reloads the LFSR (this replaces the step for that cycle); state stays RUN and in-flight operations are unaffected.
  - No transition back to SEED_WAIT except via reset.
- Arbitration (RUN only):
  - Grant goes to the first i with req_valid[i]=1, searching from the pointer upward with wrap.
  - req_ready[i] is asserted combinationally in the same cycle; the transfer completes in that cycle.
  - After a grant to i, pointer<=(i+1) mod N_REQ. With no grant, the pointer holds.
  - At most one grant per cycle, giving one issue per cycle at full throughput. No starvation: each requester waits at most N_REQ-1 issues.
- Issue cycle t (grant to i):
  - g_i0_s0/s1 = req_a_s0[i]/req_a_s1[i]; g_i1_s0/s1 = req_b_s0[i]/req_b_s1[i].
  - g_rand = LFSR[0] (registered value).
  - Tag stage 1 <= {valid=1, id=i}.
- Non-issue cycles in RUN:
  - All g_i* are driven to 0; g_rand still = LFSR[0].
  - Tag stage 1 <= invalid.
- Each LFSR output bit is presented to the gadget for exactly one cycle and never reused for a second operation.
- Share separation: s0 and s1 of one operand are never combined in any logic here; muxing is per share, selected by one-hot grant.
- Tag pipeline:
  - Tag stage 2 <= tag stage 1 every cycle.
  - In cycle t+2, if tag stage 2 is valid:
    - rsp_valid[id]=1 and rsp_id=id;
    - rsp_s0=g_o0_s0 and rsp_s1=g_o0_s1 (combinational pass-through).
  - Otherwise rsp_valid=0 and rsp_s0=rsp_s1=rsp_id=0.
- Latency is exactly 2 cycles from grant to rsp_valid.
- No response backpressure; requesters must accept results when strobed.
- Simultaneous response and grant to the same requester is legal; both occur.
- req_valid may drop without a grant; no request state is held.

Test Plan:
1. Before seeding, pulse req_valid=4'b1111 for 5 cycles -> req_ready=0 and rsp_valid=0 throughout. Then seed_valid=1, seed=0 -> seeded stays 0.
2. Seed 0x00000001, then req_valid[0]=1 with A=(s0=1,s1=0), B=(s0=0,s1=1) -> req_ready[0]=1 at t, rsp_valid[0]=1 and rsp_id=0 at t+2, rsp_s0^rsp_s1=1. Sweep all 16 share combinations: XOR of outputs = (a0^a1)&(b0^b1).
3. All four requesting continuously from pointer 0 -> grants 0,1,2,3,0,1 in consecutive cycles; responses in the same order, 2 cycles later.
4. g_rand over 64 RUN cycles after seed 0xACE1ACE1 matches a reference LFSR model bit-for-bit. On idle cycles, all g_i* are 0 while g_rand keeps stepping.
5. Issue to requesters 2 and 3 at t and t+1, assert reset_0=0 at t+1 -> no rsp_valid afterwards, seeded=0, pointer at 0 after reseed.
6. Requester 1 alone, then requesters 1 and 3 together -> after the grant to 1, requester 3 wins next; no requester waits more than 3 issues.
